// File: rtl/return_address_stack.sv
// Hardware call/return stack for the EX-stage next-address selector.
// CALL pushes a return address, RET pops it; top is valid in the pop cycle.
module return_address_stack #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned PTR_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ADDR_WIDTH-1:0] push_data,
  input  logic                  flush,
  input  logic                  clear_flags,
  output logic [ADDR_WIDTH-1:0] top,
  output logic [PTR_WIDTH:0]    count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned CNT_W = PTR_WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [ADDR_WIDTH-1:0] mem [DEPTH];

  logic [PTR_WIDTH-1:0] top_idx;
  logic [PTR_WIDTH-1:0] wr_idx;
  logic                 wr_en;
  logic [CNT_W-1:0]     count_n;
  logic                 ovf_evt;
  logic                 unf_evt;

  // Status decodes and top-of-stack read, all from registered state only.
  assign empty   = (count == '0);
  assign full    = (count == CNT_MAX);
  assign top_idx = PTR_WIDTH'(count - CNT_ONE);
  assign top     = empty ? '0 : mem[top_idx];

  // Next count, storage write and flag events; flush suppresses push/pop.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = '0;
    count_n = count;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    if (!flush) begin
      case ({push, pop})
        2'b10: begin
          if (full) begin
            ovf_evt = 1'b1;
          end else begin
            wr_en   = 1'b1;
            wr_idx  = count[PTR_WIDTH-1:0];
            count_n = count + CNT_ONE;
          end
        end
        2'b01: begin
          if (empty) begin
            unf_evt = 1'b1;
          end else begin
            count_n = count - CNT_ONE;
          end
        end
        2'b11: begin
          // Pop-then-push replaces the top in place; on empty it degrades to a push.
          wr_en = 1'b1;
          if (empty) begin
            wr_idx  = '0;
            count_n = CNT_ONE;
            unf_evt = 1'b1;
          end else begin
            wr_idx = top_idx;
          end
        end
        default: ;
      endcase
    end
  end

  // Count and sticky flags; a new event wins over clear_flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= flush ? '0 : count_n;
      overflow  <= (overflow  & ~clear_flags) | ovf_evt;
      underflow <= (underflow & ~clear_flags) | unf_evt;
    end
  end

  // Storage is not reset; only count decides which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: tb/tb_return_address_stack.sv
// Directed self-checking bench for return_address_stack.
module tb_return_address_stack;

  logic        clk;
  logic        reset;
  logic        push;
  logic        pop;
  logic [31:0] push_data;
  logic        flush;
  logic        clear_flags;
  logic [31:0] top;
  logic [4:0]  count;
  logic        empty;
  logic        full;
  logic        overflow;
  logic        underflow;

  int tests_run;
  int tests_failed;

  return_address_stack #(
    .ADDR_WIDTH(32),
    .DEPTH(16),
    .PTR_WIDTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .push_data(push_data),
    .flush(flush),
    .clear_flags(clear_flags),
    .top(top),
    .count(count),
    .empty(empty),
    .full(full),
    .overflow(overflow),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; push = 1'b0; pop = 1'b0; flush = 1'b0;
    clear_flags = 1'b0; push_data = '0;
  endtask

  task automatic do_push(input logic [31:0] d);
    push = 1'b1; push_data = d;
    tick();
    idle();
  endtask

  task automatic do_pop();
    pop = 1'b1;
    tick();
    idle();
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // status vector: {count, empty, full, overflow, underflow}
  task automatic test_reset();
    do_reset();
    tests_run++;
    if ({count, empty, full, overflow, underflow} !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_status: got cnt=%0d e=%b f=%b o=%b u=%b exp cnt=0 e=1 f=0 o=0 u=0",
               count, empty, full, overflow, underflow);
    end
    tests_run++;
    if (top !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_top: got %h exp 00000000", top);
    end
  endtask

  task automatic test_push_pop();
    do_reset();
    do_push(32'h10); do_push(32'h20); do_push(32'h30);
    tests_run++;
    if (count !== 5'd3 || top !== 32'h30) begin
      tests_failed++;
      $display("FAIL push3: got cnt=%0d top=%h exp cnt=3 top=00000030", count, top);
    end
    pop = 1'b1;
    #1;
    tests_run++;
    if (top !== 32'h30) begin
      tests_failed++;
      $display("FAIL pop_same_cycle_top: got %h exp 00000030", top);
    end
    tick();
    idle();
    tests_run++;
    if (count !== 5'd2 || top !== 32'h20) begin
      tests_failed++;
      $display("FAIL pop_after: got cnt=%0d top=%h exp cnt=2 top=00000020", count, top);
    end
    do_pop(); do_pop();
    tests_run++;
    if (top !== 32'h0 || empty !== 1'b1 || count !== 5'd0) begin
      tests_failed++;
      $display("FAIL pop_to_empty: got top=%h e=%b cnt=%0d exp top=0 e=1 cnt=0", top, empty, count);
    end
  endtask

  task automatic test_full_overflow();
    do_reset();
    for (int i = 0; i < 16; i++) do_push(32'h100 + 32'(i));
    tests_run++;
    if (full !== 1'b1 || count !== 5'd16 || top !== 32'h10F || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL fill16: got f=%b cnt=%0d top=%h o=%b exp f=1 cnt=16 top=0000010f o=0",
               full, count, top, overflow);
    end
    do_push(32'hDEAD);
    tests_run++;
    if (count !== 5'd16 || top !== 32'h10F || overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL push17_overflow: got cnt=%0d top=%h o=%b exp cnt=16 top=0000010f o=1",
               count, top, overflow);
    end
    for (int i = 0; i < 16; i++) begin
      pop = 1'b1;
      #1;
      tests_run++;
      if (top !== 32'h10F - 32'(i)) begin
        tests_failed++;
        $display("FAIL drain_order[%0d]: got %h exp %h", i, top, 32'h10F - 32'(i));
      end
      tick();
      idle();
    end
    tests_run++;
    if (empty !== 1'b1 || top !== 32'h0 || overflow !== 1'b1 || underflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL drained: got e=%b top=%h o=%b u=%b exp e=1 top=0 o=1 u=0",
               empty, top, overflow, underflow);
    end
    clear_flags = 1'b1;
    tick();
    idle();
    tests_run++;
    if (overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_overflow: got %b exp 0", overflow);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    do_pop();
    tests_run++;
    if (underflow !== 1'b1 || count !== 5'd0 || top !== 32'h0) begin
      tests_failed++;
      $display("FAIL pop_empty: got u=%b cnt=%0d top=%h exp u=1 cnt=0 top=0", underflow, count, top);
    end
    do_push(32'h44);
    tests_run++;
    if (count !== 5'd1 || underflow !== 1'b1 || top !== 32'h44) begin
      tests_failed++;
      $display("FAIL sticky_underflow: got cnt=%0d u=%b top=%h exp cnt=1 u=1 top=00000044",
               count, underflow, top);
    end
    clear_flags = 1'b1;
    tick();
    idle();
    tests_run++;
    if (underflow !== 1'b0 || count !== 5'd1) begin
      tests_failed++;
      $display("FAIL clear_underflow: got u=%b cnt=%0d exp u=0 cnt=1", underflow, count);
    end
    do_pop();
    clear_flags = 1'b1; pop = 1'b1;
    tick();
    idle();
    tests_run++;
    if (underflow !== 1'b1 || count !== 5'd0) begin
      tests_failed++;
      $display("FAIL set_wins_over_clear: got u=%b cnt=%0d exp u=1 cnt=0", underflow, count);
    end
  endtask

  task automatic test_push_pop_same();
    do_reset();
    do_push(32'h10); do_push(32'h20);
    push = 1'b1; pop = 1'b1; push_data = 32'h99;
    tick();
    idle();
    tests_run++;
    if (count !== 5'd2 || top !== 32'h99 || overflow !== 1'b0 || underflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL replace_top: got cnt=%0d top=%h o=%b u=%b exp cnt=2 top=00000099 o=0 u=0",
               count, top, overflow, underflow);
    end
    do_pop();
    tests_run++;
    if (count !== 5'd1 || top !== 32'h10) begin
      tests_failed++;
      $display("FAIL replace_keeps_below: got cnt=%0d top=%h exp cnt=1 top=00000010", count, top);
    end
    do_pop();
    push = 1'b1; pop = 1'b1; push_data = 32'h55;
    tick();
    idle();
    tests_run++;
    if (count !== 5'd1 || top !== 32'h55 || underflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL pushpop_empty: got cnt=%0d top=%h u=%b exp cnt=1 top=00000055 u=1",
               count, top, underflow);
    end
  endtask

  task automatic test_flush_reset();
    do_reset();
    for (int i = 0; i < 5; i++) do_push(32'h200 + 32'(i));
    tests_run++;
    if (count !== 5'd5 || top !== 32'h204) begin
      tests_failed++;
      $display("FAIL fill5: got cnt=%0d top=%h exp cnt=5 top=00000204", count, top);
    end
    flush = 1'b1; push = 1'b1; push_data = 32'h777;
    tick();
    idle();
    tests_run++;
    if (count !== 5'd0 || top !== 32'h0 || overflow !== 1'b0 || underflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_with_push: got cnt=%0d top=%h o=%b u=%b exp cnt=0 top=0 o=0 u=0",
               count, top, overflow, underflow);
    end
    flush = 1'b1; pop = 1'b1;
    tick();
    idle();
    tests_run++;
    if (count !== 5'd0 || underflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_with_pop_empty: got cnt=%0d u=%b exp cnt=0 u=0", count, underflow);
    end
    for (int i = 0; i < 17; i++) do_push(32'h300 + 32'(i));
    flush = 1'b1;
    tick();
    idle();
    tests_run++;
    if (count !== 5'd0 || overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_keeps_flag: got cnt=%0d o=%b exp cnt=0 o=1", count, overflow);
    end
    reset = 1'b1; push = 1'b1; push_data = 32'hABC;
    tick();
    idle();
    tests_run++;
    if (count !== 5'd0 || top !== 32'h0 || overflow !== 1'b0 || underflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_over_push: got cnt=%0d top=%h o=%b u=%b exp cnt=0 top=0 o=0 u=0",
               count, top, overflow, underflow);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    idle();
    test_reset();
    test_push_pop();
    test_full_overflow();
    test_underflow();
    test_push_pop_same();
    test_flush_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
